btn_debounce: RTL and testbench

Debounces and synchronises the raw on-board push-buttons and turns each into a clean level plus single-cycle press/release pulses and a press-toggled latch. Sits directly upstream of the uptime BCD counter in the 0.5 MHz clock domain: its outputs drive the counter's `rst` (from the press level) and `ce` (from the hold latch), replacing the raw `BTN` inversions.

---
 rtl/btn_pkg.sv | 35 +++
 rtl/btn_debounce_ch.sv | 135 +++++++++++++
 rtl/btn_debounce.sv | 37 +++
 tb/tb_btn_debounce.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: channel FSM states and
// width helpers for the per-channel qualification counter.
package btn_pkg;

    // Channel FSM states; encodings are fixed so they read the same in any dump.
    typedef enum logic [1:0] {
        REL   = 2'd0,  // released, stable
        PWAIT = 2'd1,  // press qualifying
        PRS   = 2'd2,  // pressed, stable
        RWAIT = 2'd3   // release qualifying
    } state_t;

    // Largest supported stability count; keeps the counter at 4 bits or less.
    localparam int unsigned STABLE_MAX = 15;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Smallest width able to hold the value itself (never less than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned value);
        int unsigned w;
        w = clog2(value + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, 4-state qualification FSM with a
// saturating sample counter, and registered level / press / release / toggle.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned P_STABLE     = 4,
    parameter bit          P_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_toggle
);

    localparam int unsigned         CNT_W    = cnt_width(P_STABLE);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(P_STABLE - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ZERO = '0;
    // Raw pin level while the button is not pressed.
    localparam logic                RAW_IDLE = P_ACTIVE_LOW;

    logic [1:0]       sync_q;
    logic             sample;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             toggle_q, toggle_d;

    // Synchroniser runs every clk; resets to the released pin level so that
    // reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{RAW_IDLE}};
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    // Normalised sample: 1 = pressed regardless of pin polarity.
    assign sample = sync_q[1] ^ RAW_IDLE;

    // Next-state logic; FSM and counter only move on sample_en cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sample_en) begin
            unique case (state_q)
                REL: begin
                    cnt_d = CNT_ZERO;
                    if (sample) begin
                        if (P_STABLE == 1) begin
                            state_d = PRS;
                            press_d = 1'b1;
                        end else begin
                            state_d = PWAIT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                PWAIT: begin
                    if (!sample) begin
                        state_d = REL;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRS;
                        cnt_d   = CNT_ZERO;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PRS: begin
                    cnt_d = CNT_ZERO;
                    if (!sample) begin
                        if (P_STABLE == 1) begin
                            state_d   = REL;
                            release_d = 1'b1;
                        end else begin
                            state_d = RWAIT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                RWAIT: begin
                    if (sample) begin
                        state_d = PRS;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = REL;
                        cnt_d     = CNT_ZERO;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
        // Level follows the state being entered so it moves on the same edge.
        level_d  = (state_d == PRS) || (state_d == RWAIT);
        toggle_d = toggle_q ^ press_d;
    end

    // State, counter and output registers; reset discards any qualification.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= REL;
            cnt_q     <= CNT_ZERO;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_toggle  = toggle_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-button debouncer: one independent channel per button, no shared logic.
// Feeds the uptime counter with a clean press level and a press-toggled latch.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned P_BUTTONS    = 2,
    parameter int unsigned P_STABLE     = 4,
    parameter bit          P_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic [P_BUTTONS-1:0] btn_raw,
    output logic [P_BUTTONS-1:0] btn_level,
    output logic [P_BUTTONS-1:0] btn_press,
    output logic [P_BUTTONS-1:0] btn_release,
    output logic [P_BUTTONS-1:0] btn_toggle
);

    // One channel instance per button.
    for (genvar i = 0; i < int'(P_BUTTONS); i++) begin : g_ch
        btn_debounce_ch #(
            .P_STABLE     (P_STABLE),
            .P_ACTIVE_LOW (P_ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .sample_en   (sample_en),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_toggle  (btn_toggle[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: P_STABLE = 4, active-low pins,
// sample_en every 8 clk.
module tb_btn_debounce;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       sample_en = 1'b0;
    logic [1:0] btn_raw   = 2'b11;
    logic [1:0] btn_level, btn_press, btn_release, btn_toggle;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse counters sampled on the falling edge; a 2-clk pulse counts twice.
    int press_cnt   [2] = '{0, 0};
    int release_cnt [2] = '{0, 0};
    int overlap_cnt     = 0;

    always #5 clk = ~clk;

    btn_debounce #(
        .P_BUTTONS    (2),
        .P_STABLE     (4),
        .P_ACTIVE_LOW (1'b1)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_toggle  (btn_toggle)
    );

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (btn_press[c] === 1'b1) press_cnt[c] <= press_cnt[c] + 1;
            if (btn_release[c] === 1'b1) release_cnt[c] <= release_cnt[c] + 1;
            if ((btn_press[c] & btn_release[c]) === 1'b1) overlap_cnt <= overlap_cnt + 1;
        end
    end

    // Advance one clk; return 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sample period: 7 idle clk then one clk with sample_en high.
    task automatic sample();
        sample_en = 1'b0;
        repeat (7) tick();
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic apply_reset(input logic [1:0] raw);
        btn_raw   = raw;
        sample_en = 1'b0;
        rst       = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int p0, p1;
        btn_raw   = 2'b00;
        rst       = 1'b1;
        sample_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({btn_level, btn_press, btn_release, btn_toggle} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b expected %b",
                         {btn_level, btn_press, btn_release, btn_toggle}, 8'h00);
            end
        end
        rst       = 1'b0;
        sample_en = 1'b0;
        p0 = press_cnt[0];
        p1 = press_cnt[1];
        repeat (3) sample();
        n_tests++;
        if (btn_level !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_held_early: level %b expected %b", btn_level, 2'b00);
        end
        sample();
        n_tests++;
        if ({btn_level, btn_press, btn_toggle} !== 6'b11_11_11) begin
            n_fail++;
            $display("FAIL reset_held_accept: lvl/prs/tog %b expected %b",
                     {btn_level, btn_press, btn_toggle}, 6'b11_11_11);
        end
        tick();
        n_tests++;
        if (btn_press !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_press_width: press %b expected %b", btn_press, 2'b00);
        end
        n_tests++;
        if (press_cnt[0] - p0 != 1 || press_cnt[1] - p1 != 1) begin
            n_fail++;
            $display("FAIL reset_press_count: got %0d/%0d expected 1/1",
                     press_cnt[0] - p0, press_cnt[1] - p1);
        end
    endtask

    task automatic test_clean_press();
        int p0, p1, r0, r1;
        apply_reset(2'b11);
        p0 = press_cnt[0]; p1 = press_cnt[1];
        r0 = release_cnt[0]; r1 = release_cnt[1];
        btn_raw = 2'b10;
        repeat (3) sample();
        n_tests++;
        if (btn_level !== 2'b00 || btn_press !== 2'b00) begin
            n_fail++;
            $display("FAIL clean_early: level %b press %b expected 00 00", btn_level, btn_press);
        end
        sample();
        n_tests++;
        if ({btn_level, btn_press, btn_toggle} !== 6'b01_01_01) begin
            n_fail++;
            $display("FAIL clean_accept: lvl/prs/tog %b expected %b",
                     {btn_level, btn_press, btn_toggle}, 6'b01_01_01);
        end
        tick();
        n_tests++;
        if (btn_press !== 2'b00) begin
            n_fail++;
            $display("FAIL clean_press_width: press %b expected %b", btn_press, 2'b00);
        end
        repeat (2) sample();
        n_tests++;
        if (press_cnt[0] - p0 != 1 || press_cnt[1] != p1 || release_cnt[0] != r0
            || release_cnt[1] != r1 || {btn_level, btn_toggle} !== 4'b01_01) begin
            n_fail++;
            $display("FAIL clean_hold: p0=%0d p1=%0d lvl %b tog %b expected 1 0 01 01",
                     press_cnt[0] - p0, press_cnt[1] - p1, btn_level, btn_toggle);
        end
    endtask

    task automatic test_bounce();
        int p0, r0;
        apply_reset(2'b11);
        p0 = press_cnt[0];
        r0 = release_cnt[0];
        btn_raw = 2'b10;
        repeat (3) sample();
        btn_raw = 2'b11;
        sample();
        btn_raw = 2'b10;
        repeat (3) sample();
        n_tests++;
        if (btn_level !== 2'b00 || press_cnt[0] != p0) begin
            n_fail++;
            $display("FAIL bounce_early: level %b presses %0d expected 00 0",
                     btn_level, press_cnt[0] - p0);
        end
        sample();
        n_tests++;
        if (btn_press !== 2'b01 || btn_level !== 2'b01) begin
            n_fail++;
            $display("FAIL bounce_accept: press %b level %b expected 01 01", btn_press, btn_level);
        end
        tick();
        n_tests++;
        if (press_cnt[0] - p0 != 1 || release_cnt[0] != r0) begin
            n_fail++;
            $display("FAIL bounce_counts: presses %0d releases %0d expected 1 0",
                     press_cnt[0] - p0, release_cnt[0] - r0);
        end
    endtask

    task automatic test_release_toggle();
        int p1, r1, p0;
        logic [1:0] exp_tog;
        apply_reset(2'b11);
        p1 = press_cnt[1]; r1 = release_cnt[1]; p0 = press_cnt[0];
        exp_tog = 2'b00;
        for (int k = 0; k < 2; k++) begin
            exp_tog[1] = ~exp_tog[1];
            btn_raw = 2'b01;
            repeat (4) sample();
            n_tests++;
            if ({btn_press, btn_level, btn_toggle} !== {2'b10, 2'b10, exp_tog}) begin
                n_fail++;
                $display("FAIL toggle_press%0d: prs/lvl/tog %b expected %b", k,
                         {btn_press, btn_level, btn_toggle}, {2'b10, 2'b10, exp_tog});
            end
            btn_raw = 2'b11;
            repeat (3) sample();
            n_tests++;
            if (btn_level !== 2'b10 || btn_release !== 2'b00) begin
                n_fail++;
                $display("FAIL toggle_rwait%0d: level %b release %b expected 10 00", k,
                         btn_level, btn_release);
            end
            sample();
            n_tests++;
            if ({btn_release, btn_level, btn_toggle} !== {2'b10, 2'b00, exp_tog}) begin
                n_fail++;
                $display("FAIL toggle_release%0d: rel/lvl/tog %b expected %b", k,
                         {btn_release, btn_level, btn_toggle}, {2'b10, 2'b00, exp_tog});
            end
        end
        tick();
        n_tests++;
        if (press_cnt[1] - p1 != 2 || release_cnt[1] - r1 != 2 || press_cnt[0] != p0
            || overlap_cnt != 0 || btn_toggle !== 2'b00) begin
            n_fail++;
            $display("FAIL toggle_counts: p1=%0d r1=%0d p0=%0d ovl=%0d tog %b expected 2 2 0 0 00",
                     press_cnt[1] - p1, release_cnt[1] - r1, press_cnt[0] - p0,
                     overlap_cnt, btn_toggle);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset(2'b11);
        btn_raw = 2'b00;
        repeat (3) sample();
        n_tests++;
        if (btn_press !== 2'b00) begin
            n_fail++;
            $display("FAIL simul_early: press %b expected %b", btn_press, 2'b00);
        end
        sample();
        n_tests++;
        if (btn_press !== 2'b11 || btn_level !== 2'b11) begin
            n_fail++;
            $display("FAIL simul_accept: press %b level %b expected 11 11", btn_press, btn_level);
        end
    endtask

    task automatic test_reset_qual();
        int p0;
        apply_reset(2'b11);
        btn_raw = 2'b01;
        repeat (4) sample();
        btn_raw = 2'b00;
        repeat (2) sample();
        n_tests++;
        if (btn_level !== 2'b10 || btn_toggle !== 2'b10) begin
            n_fail++;
            $display("FAIL rq_setup: level %b toggle %b expected 10 10", btn_level, btn_toggle);
        end
        p0 = press_cnt[0];
        rst       = 1'b1;
        sample_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({btn_level, btn_press, btn_release, btn_toggle} !== 8'h00) begin
                n_fail++;
                $display("FAIL rq_reset_outputs: got %b expected %b",
                         {btn_level, btn_press, btn_release, btn_toggle}, 8'h00);
            end
        end
        rst       = 1'b0;
        sample_en = 1'b0;
        repeat (3) sample();
        n_tests++;
        if (btn_level !== 2'b00 || press_cnt[0] != p0) begin
            n_fail++;
            $display("FAIL rq_restart: level %b presses %0d expected 00 0",
                     btn_level, press_cnt[0] - p0);
        end
        sample();
        n_tests++;
        if ({btn_press, btn_level, btn_toggle} !== 6'b11_11_11) begin
            n_fail++;
            $display("FAIL rq_accept: prs/lvl/tog %b expected %b",
                     {btn_press, btn_level, btn_toggle}, 6'b11_11_11);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_toggle();
        test_simultaneous();
        test_reset_qual();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
